// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer and valid/ready on both sides.
// Optional M extension is enabled by defining DECODE_RV32M_EN.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter int CU_OP_W  = 6,
   parameter int ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                nRst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [XLEN-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [CU_OP_W-1:0]  out_cu_op,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [4:0]          out_rd,
   output logic [XLEN-1:0]     out_imm,
   output logic                out_reg_write,
   output logic                out_mem_read,
   output logic                out_mem_write,
   output logic                out_branch,
   output logic                out_alu_src,
   output logic                out_illegal
);

   localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
   localparam logic [6:0] OPC_OP_IMM = 7'h13, OPC_OP = 7'h33;

   localparam logic [CU_OP_W-1:0] CU_ERROR = CU_OP_W'(0),  CU_LUI   = CU_OP_W'(1),  CU_AUIPC = CU_OP_W'(2);
   localparam logic [CU_OP_W-1:0] CU_JAL   = CU_OP_W'(3),  CU_JALR  = CU_OP_W'(4),  CU_BEQ   = CU_OP_W'(5);
   localparam logic [CU_OP_W-1:0] CU_BNE   = CU_OP_W'(6),  CU_BLT   = CU_OP_W'(7),  CU_BGE   = CU_OP_W'(8);
   localparam logic [CU_OP_W-1:0] CU_BLTU  = CU_OP_W'(9),  CU_BGEU  = CU_OP_W'(10), CU_LB    = CU_OP_W'(11);
   localparam logic [CU_OP_W-1:0] CU_LH    = CU_OP_W'(12), CU_LW    = CU_OP_W'(13), CU_LBU   = CU_OP_W'(14);
   localparam logic [CU_OP_W-1:0] CU_LHU   = CU_OP_W'(15), CU_SB    = CU_OP_W'(16), CU_SH    = CU_OP_W'(17);
   localparam logic [CU_OP_W-1:0] CU_SW    = CU_OP_W'(18), CU_ADDI  = CU_OP_W'(19), CU_SLTI  = CU_OP_W'(20);
   localparam logic [CU_OP_W-1:0] CU_SLTIU = CU_OP_W'(21), CU_XORI  = CU_OP_W'(22), CU_ORI   = CU_OP_W'(23);
   localparam logic [CU_OP_W-1:0] CU_ANDI  = CU_OP_W'(24), CU_SLLI  = CU_OP_W'(25), CU_SRLI  = CU_OP_W'(26);
   localparam logic [CU_OP_W-1:0] CU_SRAI  = CU_OP_W'(27), CU_ADD   = CU_OP_W'(28), CU_SUB   = CU_OP_W'(29);
   localparam logic [CU_OP_W-1:0] CU_SLL   = CU_OP_W'(30), CU_SLT   = CU_OP_W'(31), CU_SLTU  = CU_OP_W'(32);
   localparam logic [CU_OP_W-1:0] CU_XOR   = CU_OP_W'(33), CU_SRL   = CU_OP_W'(34), CU_SRA   = CU_OP_W'(35);
   localparam logic [CU_OP_W-1:0] CU_OR    = CU_OP_W'(36), CU_AND   = CU_OP_W'(37);

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0), ALU_SUB  = ALU_OP_W'(1), ALU_SLL = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(3), ALU_SLTU = ALU_OP_W'(4), ALU_XOR = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(6), ALU_SRA  = ALU_OP_W'(7), ALU_OR  = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(9);

`ifdef DECODE_RV32M_EN
   localparam logic [CU_OP_W-1:0] CU_MUL  = CU_OP_W'(38), CU_MULH = CU_OP_W'(39), CU_MULHSU = CU_OP_W'(40);
   localparam logic [CU_OP_W-1:0] CU_MULHU = CU_OP_W'(41), CU_DIV = CU_OP_W'(42), CU_DIVU   = CU_OP_W'(43);
   localparam logic [CU_OP_W-1:0] CU_REM  = CU_OP_W'(44), CU_REMU = CU_OP_W'(45);
   // The divider yields quotient and remainder together; cu_op selects which one REM/REMU keep.
   localparam logic [ALU_OP_W-1:0] ALU_MUL   = ALU_OP_W'(10), ALU_MULH = ALU_OP_W'(11), ALU_MULHSU = ALU_OP_W'(12);
   localparam logic [ALU_OP_W-1:0] ALU_MULHU = ALU_OP_W'(13), ALU_DIV  = ALU_OP_W'(14), ALU_DIVU   = ALU_OP_W'(15);
`endif

   localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0]     pc;
      logic [CU_OP_W-1:0]  cu_op;
      logic [ALU_OP_W-1:0] alu_op;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [XLEN-1:0]     imm;
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic                branch;
      logic                alu_src;
      logic                illegal;
   } bundle_t;

   logic [6:0]          opcode, funct7;
   logic [2:0]          funct3;
   logic [31:0]         imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
   logic [CU_OP_W-1:0]  cu;
   logic [ALU_OP_W-1:0] alu;
   logic                use_rs1, use_rs2, use_rd, rw, mr, mw, br, asrc, bad;
   bundle_t             dec, main_reg, skid_reg, main_next;
   logic [1:0]          state_reg, state_next;
   logic                accept, retire, load_main, load_skid;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign imm_i  = {{21{in_instr[31]}}, in_instr[30:20]};
   assign imm_s  = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
   assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   // Upper-immediate and jump ops use ALU_ADD; execute picks x0/pc as operand A from cu_op.
   always_comb begin
      cu = CU_ERROR; alu = ALU_ADD; imm32 = 32'd0;
      use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
      rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; asrc = 1'b0; bad = 1'b0;
      case (opcode)
         OPC_LUI: begin
            cu = CU_LUI; imm32 = imm_u; use_rd = 1'b1; rw = 1'b1; asrc = 1'b1;
         end
         OPC_AUIPC: begin
            cu = CU_AUIPC; imm32 = imm_u; use_rd = 1'b1; rw = 1'b1; asrc = 1'b1;
         end
         OPC_JAL: begin
            cu = CU_JAL; imm32 = imm_j; use_rd = 1'b1; rw = 1'b1; asrc = 1'b1;
         end
         OPC_JALR: begin
            cu = CU_JALR; imm32 = imm_i; use_rs1 = 1'b1; use_rd = 1'b1; rw = 1'b1; asrc = 1'b1;
            bad = (funct3 != 3'd0);
         end
         OPC_BRANCH: begin
            imm32 = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; br = 1'b1; alu = ALU_SUB;
            case (funct3)
               3'd0: cu = CU_BEQ;
               3'd1: cu = CU_BNE;
               3'd4: cu = CU_BLT;
               3'd5: cu = CU_BGE;
               3'd6: cu = CU_BLTU;
               3'd7: cu = CU_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            imm32 = imm_i; use_rs1 = 1'b1; use_rd = 1'b1; rw = 1'b1; mr = 1'b1; asrc = 1'b1;
            case (funct3)
               3'd0: cu = CU_LB;
               3'd1: cu = CU_LH;
               3'd2: cu = CU_LW;
               3'd4: cu = CU_LBU;
               3'd5: cu = CU_LHU;
               default: bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            imm32 = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; mw = 1'b1; asrc = 1'b1;
            case (funct3)
               3'd0: cu = CU_SB;
               3'd1: cu = CU_SH;
               3'd2: cu = CU_SW;
               default: bad = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            imm32 = imm_i; use_rs1 = 1'b1; use_rd = 1'b1; rw = 1'b1; asrc = 1'b1;
            case (funct3)
               3'd0: begin cu = CU_ADDI;  alu = ALU_ADD;  end
               3'd2: begin cu = CU_SLTI;  alu = ALU_SLT;  end
               3'd3: begin cu = CU_SLTIU; alu = ALU_SLTU; end
               3'd4: begin cu = CU_XORI;  alu = ALU_XOR;  end
               3'd6: begin cu = CU_ORI;   alu = ALU_OR;   end
               3'd7: begin cu = CU_ANDI;  alu = ALU_AND;  end
               3'd1: begin cu = CU_SLLI;  alu = ALU_SLL; bad = (funct7 != 7'h00); end
               default: begin
                  if (funct7 == 7'h00)      begin cu = CU_SRLI; alu = ALU_SRL; end
                  else if (funct7 == 7'h20) begin cu = CU_SRAI; alu = ALU_SRA; end
                  else bad = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; rw = 1'b1;
            if (funct7 == 7'h00) begin
               case (funct3)
                  3'd0: begin cu = CU_ADD;  alu = ALU_ADD;  end
                  3'd1: begin cu = CU_SLL;  alu = ALU_SLL;  end
                  3'd2: begin cu = CU_SLT;  alu = ALU_SLT;  end
                  3'd3: begin cu = CU_SLTU; alu = ALU_SLTU; end
                  3'd4: begin cu = CU_XOR;  alu = ALU_XOR;  end
                  3'd5: begin cu = CU_SRL;  alu = ALU_SRL;  end
                  3'd6: begin cu = CU_OR;   alu = ALU_OR;   end
                  default: begin cu = CU_AND; alu = ALU_AND; end
               endcase
            end else if (funct7 == 7'h20) begin
               case (funct3)
                  3'd0: begin cu = CU_SUB; alu = ALU_SUB; end
                  3'd5: begin cu = CU_SRA; alu = ALU_SRA; end
                  default: bad = 1'b1;
               endcase
            end else if (funct7 == 7'h01) begin
`ifdef DECODE_RV32M_EN
               case (funct3)
                  3'd0: begin cu = CU_MUL;    alu = ALU_MUL;    end
                  3'd1: begin cu = CU_MULH;   alu = ALU_MULH;   end
                  3'd2: begin cu = CU_MULHSU; alu = ALU_MULHSU; end
                  3'd3: begin cu = CU_MULHU;  alu = ALU_MULHU;  end
                  3'd4: begin cu = CU_DIV;    alu = ALU_DIV;    end
                  3'd5: begin cu = CU_DIVU;   alu = ALU_DIVU;   end
                  3'd6: begin cu = CU_REM;    alu = ALU_DIV;    end
                  default: begin cu = CU_REMU; alu = ALU_DIVU; end
               endcase
`else
               bad = 1'b1;
`endif
            end else begin
               bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase
   end

   // Illegal encodings carry only pc, CU_ERROR and the flag; everything else is zeroed.
   always_comb begin
      dec    = '0;
      dec.pc = in_pc;
      if (bad) begin
         dec.cu_op   = CU_ERROR;
         dec.illegal = 1'b1;
      end else begin
         dec.cu_op     = cu;
         dec.alu_op    = alu;
         dec.rs1       = use_rs1 ? in_instr[19:15] : 5'd0;
         dec.rs2       = use_rs2 ? in_instr[24:20] : 5'd0;
         dec.rd        = use_rd  ? in_instr[11:7]  : 5'd0;
         dec.imm       = XLEN'($signed(imm32));
         dec.reg_write = rw && (in_instr[11:7] != 5'd0);
         dec.mem_read  = mr;
         dec.mem_write = mw;
         dec.branch    = br;
         dec.alu_src   = asrc;
      end
   end

   assign in_ready  = (state_reg != TWO);
   assign out_valid = (state_reg != EMPTY);
   assign accept    = in_valid && in_ready;
   assign retire    = out_valid && out_ready;

   always_comb begin
      state_next = state_reg;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      main_next  = dec;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: if (accept) begin load_main = 1'b1; state_next = ONE; end
            ONE: begin
               if (accept && retire) load_main = 1'b1;
               else if (accept) begin load_skid = 1'b1; state_next = TWO; end
               else if (retire) state_next = EMPTY;
            end
            TWO: if (retire) begin load_main = 1'b1; main_next = skid_reg; state_next = ONE; end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_reg <= EMPTY;
         main_reg  <= '0;
         skid_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (load_main) main_reg <= main_next;
         if (load_skid) skid_reg <= dec;
      end
   end

   assign out_pc        = main_reg.pc;
   assign out_cu_op     = main_reg.cu_op;
   assign out_alu_op    = main_reg.alu_op;
   assign out_rs1       = main_reg.rs1;
   assign out_rs2       = main_reg.rs2;
   assign out_rd        = main_reg.rd;
   assign out_imm       = main_reg.imm;
   assign out_reg_write = main_reg.reg_write;
   assign out_mem_read  = main_reg.mem_read;
   assign out_mem_write = main_reg.mem_write;
   assign out_branch    = main_reg.branch;
   assign out_alu_src   = main_reg.alu_src;
   assign out_illegal   = main_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random traffic scored against a table-driven decode model.
module tb_decode_stage;
   localparam int XLEN = 32;

   localparam int C_ERR = 0, C_LUI = 1, C_AUIPC = 2, C_JAL = 3, C_JALR = 4;
   localparam int C_BEQ = 5, C_BNE = 6, C_BLT = 7, C_BGE = 8, C_BLTU = 9, C_BGEU = 10;
   localparam int C_LB = 11, C_LH = 12, C_LW = 13, C_LBU = 14, C_LHU = 15;
   localparam int C_SB = 16, C_SH = 17, C_SW = 18;
   localparam int C_ADDI = 19, C_SLTI = 20, C_SLTIU = 21, C_XORI = 22, C_ORI = 23, C_ANDI = 24;
   localparam int C_SLLI = 25, C_SRLI = 26, C_SRAI = 27;
   localparam int C_ADD = 28, C_SUB = 29, C_SLL = 30, C_SLT = 31, C_SLTU = 32, C_XOR = 33;
   localparam int C_SRL = 34, C_SRA = 35, C_OR = 36, C_AND = 37;
   localparam int C_MUL = 38, C_MULH = 39, C_MULHSU = 40, C_MULHU = 41;
   localparam int C_DIV = 42, C_DIVU = 43, C_REM = 44, C_REMU = 45;
   localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4, A_XOR = 5;
   localparam int A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;
   localparam int A_MUL = 10, A_MULH = 11, A_MULHSU = 12, A_MULHU = 13, A_DIV = 14, A_DIVU = 15;

   logic clk = 1'b0, nRst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [XLEN-1:0] in_pc = '0;
   logic in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write, out_branch, out_alu_src, out_illegal;
   logic [XLEN-1:0] out_pc, out_imm;
   logic [5:0] out_cu_op;
   logic [3:0] out_alu_op;
   logic [4:0] out_rs1, out_rs2, out_rd;

   typedef logic [94:0] bun_t;
   bun_t dut_b;
   bun_t q[$];
   int total = 0, bad = 0;
   bit acc_last;

   decode_stage #(.XLEN(XLEN), .CU_OP_W(6), .ALU_OP_W(4)) dut (
      .clk(clk), .nRst(nRst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_cu_op(out_cu_op), .out_alu_op(out_alu_op), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
      .out_alu_src(out_alu_src), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   assign dut_b = {out_pc, out_cu_op, out_alu_op, out_rs1, out_rs2, out_rd, out_imm,
                   out_reg_write, out_mem_read, out_mem_write, out_branch, out_alu_src, out_illegal};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference decode: per-opcode format letter plus funct3 lookup tables, immediates by arithmetic.
   function automatic bun_t ref_bundle(input logic [31:0] ins, input logic [31:0] pc);
      int load_t[8]  = '{C_LB, C_LH, C_LW, -1, C_LBU, C_LHU, -1, -1};
      int store_t[8] = '{C_SB, C_SH, C_SW, -1, -1, -1, -1, -1};
      int br_t[8]    = '{C_BEQ, C_BNE, -1, -1, C_BLT, C_BGE, C_BLTU, C_BGEU};
      int opi_t[8]   = '{C_ADDI, C_SLLI, C_SLTI, C_SLTIU, C_XORI, C_SRLI, C_ORI, C_ANDI};
      int op_t[8]    = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
      int alu_t[8]   = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
      int mul_t[8]   = '{C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};
      int mula_t[8]  = '{A_MUL, A_MULH, A_MULHSU, A_MULHU, A_DIV, A_DIVU, A_DIV, A_DIVU};
      int f3 = int'(ins[14:12]);
      int f7 = int'(ins[31:25]);
      int top = ins[31] ? -1 : 0;
      int cu = -1, alu = A_ADD, imm = 0;
      byte fmt = "X";
      bit has_rs1, has_rs2, has_rd, rw;
      case (ins[6:0])
         7'h37: begin fmt = "U"; cu = C_LUI; end
         7'h17: begin fmt = "U"; cu = C_AUIPC; end
         7'h6F: begin fmt = "J"; cu = C_JAL; end
         7'h67: begin fmt = "I"; cu = (f3 == 0) ? C_JALR : -1; end
         7'h63: begin fmt = "B"; cu = br_t[f3]; alu = A_SUB; end
         7'h03: begin fmt = "I"; cu = load_t[f3]; end
         7'h23: begin fmt = "S"; cu = store_t[f3]; end
         7'h13: begin
            fmt = "I"; cu = opi_t[f3]; alu = alu_t[f3];
            if (f3 == 1 && f7 != 0) cu = -1;
            if (f3 == 5) begin
               if (f7 == 32) begin cu = C_SRAI; alu = A_SRA; end
               else if (f7 != 0) cu = -1;
            end
         end
         7'h33: begin
            fmt = "R";
            if (f7 == 0) begin cu = op_t[f3]; alu = alu_t[f3]; end
            else if (f7 == 32 && f3 == 0) begin cu = C_SUB; alu = A_SUB; end
            else if (f7 == 32 && f3 == 5) begin cu = C_SRA; alu = A_SRA; end
`ifdef DECODE_RV32M_EN
            else if (f7 == 1) begin cu = mul_t[f3]; alu = mula_t[f3]; end
`endif
         end
         default: cu = -1;
      endcase
      if (cu < 0) return {pc, 6'd0, 4'd0, 15'd0, 32'd0, 6'b000001};
      case (fmt)
         "I": imm = top * 2048 + int'(ins[30:20]);
         "S": imm = top * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
         "B": imm = top * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         "U": imm = int'(ins[31:12]) * 4096;
         "J": imm = top * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         default: imm = 0;
      endcase
      has_rs1 = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
      has_rs2 = (fmt == "R" || fmt == "S" || fmt == "B");
      has_rd  = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J");
      rw      = has_rd && (ins[11:7] != 5'd0);
      return {pc, 6'(cu), 4'(alu), has_rs1 ? ins[19:15] : 5'd0, has_rs2 ? ins[24:20] : 5'd0,
              has_rd ? ins[11:7] : 5'd0, 32'(imm), rw, ins[6:0] == 7'h03, ins[6:0] == 7'h23,
              ins[6:0] == 7'h63, fmt != "R" && fmt != "B", 1'b0};
   endfunction

   // One clock: update the scoreboard from the inputs present at the edge, then check on the falling edge.
   task automatic tick();
      bit acc, ret;
      @(posedge clk);
      acc = in_valid && (q.size() < 2);
      ret = out_ready && (q.size() > 0);
      acc_last = acc && !flush;
      if (flush) q.delete();
      else begin
         if (ret) begin
            $display("retire pc=%h bundle=%h", q[0][94:63], q[0]);
            void'(q.pop_front());
         end
         if (acc) q.push_back(ref_bundle(in_instr, in_pc));
      end
      @(negedge clk);
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) check("bundle", dut_b, q[0]);
   endtask

   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit rdy, input bit fl);
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
      tick();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops[10] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
      logic [31:0] r = $urandom;
      int k = $urandom_range(0, 10);
      if (k < 10) r[6:0] = ops[k];
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         2: r[31:25] = 7'h01;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      bit have = 1'b0;
      logic [31:0] rins = '0, rpc = 32'h1000;

      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_ready", in_ready, 1'b1);
      check("rst_bundle", dut_b, 95'd0);
      nRst = 1'b1;

      drive(1, 32'hFFF00093, 32'h100, 1, 0);
      check("addi_valid", out_valid, 1'b1);
      check("addi_cu", out_cu_op, 6'(C_ADDI));
      check("addi_rd", out_rd, 5'd1);
      check("addi_rs1", out_rs1, 5'd0);
      check("addi_imm", out_imm, 32'hFFFF_FFFF);
      check("addi_rw", out_reg_write, 1'b1);
      drive(1, 32'hFE208EE3, 32'h104, 1, 0);
      check("beq_cu", out_cu_op, 6'(C_BEQ));
      check("beq_branch", out_branch, 1'b1);
      check("beq_rs", {out_rs1, out_rs2}, {5'd1, 5'd2});
      check("beq_imm", out_imm, 32'hFFFF_FFFC);
      check("beq_rw", out_reg_write, 1'b0);
      drive(1, 32'h00512423, 32'h108, 1, 0);
      check("sw_cu", out_cu_op, 6'(C_SW));
      check("sw_mw", out_mem_write, 1'b1);
      check("sw_imm", out_imm, 32'd8);
      drive(1, 32'h022081B3, 32'h10C, 1, 0);
`ifdef DECODE_RV32M_EN
      check("mul_cu", out_cu_op, 6'(C_MUL));
      check("mul_rw", out_reg_write, 1'b1);
`else
      check("mul_illegal", out_illegal, 1'b1);
      check("mul_cu", out_cu_op, 6'(C_ERR));
`endif
      drive(1, 32'hFFFFFFFF, 32'h110, 1, 0);
      check("ones_illegal", out_illegal, 1'b1);
      check("ones_strobes", {out_reg_write, out_mem_read, out_mem_write, out_branch}, 4'd0);
      drive(0, 32'h0, 32'h0, 1, 0);

      // Back-pressure: three offered, two held, third waits until a slot frees.
      drive(1, 32'h00100093, 32'h200, 0, 0);
      drive(1, 32'h00200113, 32'h204, 0, 0);
      drive(1, 32'h00300193, 32'h208, 0, 0);
      check("stall_ready", in_ready, 1'b0);
      check("stall_head_pc", out_pc, 32'h200);
      drive(1, 32'h00300193, 32'h208, 1, 0);
      check("stall_second_pc", out_pc, 32'h204);
      drive(1, 32'h00300193, 32'h208, 1, 0);
      check("stall_third_pc", out_pc, 32'h208);
      drive(0, 32'h0, 32'h0, 1, 0);
      check("stall_drained", out_valid, 1'b0);

      // Flush while full, with a concurrent offer that must be discarded.
      drive(1, 32'h00400213, 32'h300, 0, 0);
      drive(1, 32'h00500293, 32'h304, 0, 0);
      drive(1, 32'h00600313, 32'h308, 0, 1);
      check("flush_valid", out_valid, 1'b0);
      check("flush_ready", in_ready, 1'b1);
      drive(0, 32'h0, 32'h0, 1, 0);
      drive(0, 32'h0, 32'h0, 1, 0);

      // Asynchronous reset while full.
      drive(1, 32'h00700393, 32'h400, 0, 0);
      drive(1, 32'h00800413, 32'h404, 0, 0);
      #2 nRst = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_ready", in_ready, 1'b1);
      check("arst_cu", out_cu_op, 6'd0);
      q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      nRst = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            rins = rand_instr();
            rpc  = rpc + 32'd4;
            have = 1'b1;
         end
         drive(have, rins, rpc, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
         if (acc_last || flush) have = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
